// File: rtl/updown_counter_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : updown_counter_ctrl
// Purpose  : Up/down counter with control FSM, tick prescaler and coded
//            error reporting. Counting advances on an internal enable tick.
// Revision : 1.0  initial release
// ============================================================================
module updown_counter_ctrl #(
  parameter int WIDTH   = 8,
  parameter int DIVISOR = 50,
  parameter int WRAP    = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             mode,
  input  logic             load,
  input  logic             clear,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic             running,
  output logic             dir,
  output logic             loading,
  output logic             tick,
  output logic             error,
  output logic [1:0]       err_code
);

  localparam int PW = (DIVISOR > 2) ? $clog2(DIVISOR) : 1;
  localparam logic [PW-1:0]    PMAX = PW'(DIVISOR - 1);
  localparam logic [WIDTH-1:0] CMAX = '1;
  localparam logic [WIDTH-1:0] CMIN = '0;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_UP   = 3'd2,
    S_DOWN = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] count_nxt;
  logic [1:0]       code_nxt;
  logic [PW-1:0]    presc;
  logic [PW-1:0]    presc_nxt;
  logic             active;
  logic             step;
  logic             active_nxt;

  // Step strobe: last prescaler cycle while counting
  assign active = (state == S_UP) || (state == S_DOWN);
  assign step   = active && (presc == PMAX);
  assign tick   = step;

  // Next-state, next-count and error-code logic; clear wins outside ERR
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    code_nxt  = err_code;
    if (clear && (state != S_ERR)) begin
      state_nxt = S_IDLE;
      count_nxt = CMIN;
      code_nxt  = 2'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (load)       state_nxt = S_LOAD;
          else if (start) state_nxt = mode ? S_DOWN : S_UP;
        end
        S_LOAD: begin
          count_nxt = load_value;
          if (!start)    state_nxt = S_IDLE;
          else if (mode) state_nxt = S_DOWN;
          else           state_nxt = S_UP;
        end
        S_UP: begin
          if (!start) begin
            state_nxt = S_IDLE;
          end else if (mode) begin
            state_nxt = S_ERR;
            code_nxt  = 2'd1;
          end else if (load) begin
            state_nxt = S_ERR;
            code_nxt  = 2'd2;
          end else if (step) begin
            if (count == CMAX) begin
              if (WRAP != 0) begin
                count_nxt = CMIN;
              end else begin
                state_nxt = S_ERR;
                code_nxt  = 2'd3;
              end
            end else begin
              count_nxt = count + WIDTH'(1);
            end
          end
        end
        S_DOWN: begin
          if (!start) begin
            state_nxt = S_IDLE;
          end else if (!mode) begin
            state_nxt = S_ERR;
            code_nxt  = 2'd1;
          end else if (load) begin
            state_nxt = S_ERR;
            code_nxt  = 2'd2;
          end else if (step) begin
            if (count == CMIN) begin
              if (WRAP != 0) begin
                count_nxt = CMAX;
              end else begin
                state_nxt = S_ERR;
                code_nxt  = 2'd3;
              end
            end else begin
              count_nxt = count - WIDTH'(1);
            end
          end
        end
        S_ERR: begin
          // Sticky until acknowledged with the run request dropped
          if (clear && !start) begin
            state_nxt = S_IDLE;
            code_nxt  = 2'd0;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Prescaler runs only while staying in UP/DOWN; any exit restarts it at 0
  always_comb begin
    active_nxt = (state_nxt == S_UP) || (state_nxt == S_DOWN);
    if (active && active_nxt)
      presc_nxt = (presc == PMAX) ? '0 : presc + PW'(1);
    else
      presc_nxt = '0;
  end

  // State, datapath and Moore status flags registered together
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      count    <= '0;
      presc    <= '0;
      err_code <= 2'd0;
      running  <= 1'b0;
      dir      <= 1'b0;
      loading  <= 1'b0;
      error    <= 1'b0;
    end else begin
      state    <= state_nxt;
      count    <= count_nxt;
      presc    <= presc_nxt;
      err_code <= code_nxt;
      running  <= active_nxt;
      dir      <= (state_nxt == S_DOWN);
      loading  <= (state_nxt == S_LOAD);
      error    <= (state_nxt == S_ERR);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_updown_counter_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_updown_counter_ctrl
// Purpose  : Directed self-checking bench, WIDTH=4 DIVISOR=4, one instance
//            with WRAP=1 and one with WRAP=0 sharing the same stimulus.
// Revision : 1.0  initial release
// ============================================================================
module tb_updown_counter_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start, mode, load, clear;
  logic [3:0] load_value;

  logic [3:0] count,  count0;
  logic       running, dir, loading, tick, error;
  logic       running0, dir0, loading0, tick0, error0;
  logic [1:0] err_code, err_code0;

  int checks   = 0;
  int failures = 0;

  updown_counter_ctrl #(.WIDTH(4), .DIVISOR(4), .WRAP(1)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .load(load),
    .clear(clear), .load_value(load_value), .count(count),
    .running(running), .dir(dir), .loading(loading), .tick(tick),
    .error(error), .err_code(err_code)
  );

  updown_counter_ctrl #(.WIDTH(4), .DIVISOR(4), .WRAP(0)) dut0 (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .load(load),
    .clear(clear), .load_value(load_value), .count(count0),
    .running(running0), .dir(dir0), .loading(loading0), .tick(tick0),
    .error(error0), .err_code(err_code0)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 ns past the edge
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Directed sequence
  initial begin
    reset = 1'b1; start = 1'b0; mode = 1'b0; load = 1'b0; clear = 1'b0;
    load_value = 4'h0;
    step(2);
    chk("rst_count",   count,    4'h0);
    chk("rst_running", running,  1'b0);
    chk("rst_dir",     dir,      1'b0);
    chk("rst_loading", loading,  1'b0);
    chk("rst_tick",    tick,     1'b0);
    chk("rst_error",   error,    1'b0);
    chk("rst_code",    err_code, 2'd0);

    // 1: count up, tick every 4 cycles
    reset = 1'b0; start = 1'b1; mode = 1'b0;
    step(1);
    chk("t1_running", running, 1'b1);
    chk("t1_dir",     dir,     1'b0);
    chk("t1_tick0",   tick,    1'b0);
    step(2);
    chk("t1_notick",  tick,    1'b0);
    step(1);
    chk("t1_tick1",   tick,    1'b1);
    chk("t1_cnt0",    count,   4'h0);
    step(1);
    chk("t1_cnt1",    count,   4'h1);
    chk("t1_tickoff", tick,    1'b0);
    step(3);
    chk("t1_tick2",   tick,    1'b1);
    step(1);
    chk("t1_cnt2",    count,   4'h2);

    // 2: load D then count down
    start = 1'b0;
    step(1);
    chk("t2_idle_run", running, 1'b0);
    chk("t2_idle_cnt", count,   4'h2);
    load = 1'b1; load_value = 4'hD;
    step(1);
    chk("t2_loading",  loading, 1'b1);
    load = 1'b0; start = 1'b1; mode = 1'b1;
    step(1);
    chk("t2_cntD",     count,   4'hD);
    chk("t2_loadoff",  loading, 1'b0);
    chk("t2_dir",      dir,     1'b1);
    chk("t2_running",  running, 1'b1);
    step(4);
    chk("t2_cntC",     count,   4'hC);

    // 3: up from E through the top bound
    start = 1'b0; mode = 1'b0;
    step(1);
    load = 1'b1; load_value = 4'hE; start = 1'b1;
    step(1);
    load = 1'b0;
    step(1);
    chk("t3_cntE",     count,    4'hE);
    step(4);
    chk("t3_cntF",     count,    4'hF);
    chk("t3_w0_cntF",  count0,   4'hF);
    step(3);
    chk("t3_w0_tick",  tick0,    1'b1);
    step(1);
    chk("t3_wrap0",    count,    4'h0);
    chk("t3_wrap_run", running,  1'b1);
    chk("t3_w0_err",   error0,   1'b1);
    chk("t3_w0_code",  err_code0, 2'd3);
    chk("t3_w0_hold",  count0,   4'hF);
    chk("t3_w0_run",   running0, 1'b0);

    // 4: mode change while running up -> code 1
    step(4);
    chk("t4_cnt1",     count,    4'h1);
    mode = 1'b1;
    step(1);
    chk("t4_err",      error,    1'b1);
    chk("t4_code1",    err_code, 2'd1);
    chk("t4_errrun",   running,  1'b0);
    clear = 1'b1;
    step(1);
    chk("t4_sticky",   error,    1'b1);
    chk("t4_stcode",   err_code, 2'd1);
    start = 1'b0;
    step(1);
    chk("t4_exit",     error,    1'b0);
    chk("t4_exitcode", err_code, 2'd0);
    chk("t4_exitcnt",  count,    4'h1);
    chk("t4_w0_code",  err_code0, 2'd0);
    chk("t4_w0_cnt",   count0,   4'hF);
    // load while running down -> code 2
    clear = 1'b0; start = 1'b1; mode = 1'b1;
    step(1);
    chk("t4_down",     dir,      1'b1);
    load = 1'b1;
    step(1);
    chk("t4_code2",    err_code, 2'd2);
    chk("t4_err2",     error,    1'b1);
    load = 1'b0; clear = 1'b1; start = 1'b0;
    step(1);
    chk("t4_exit2",    error,    1'b0);
    chk("t4_cnt2",     count,    4'h1);

    // 5: tick coinciding with start=0 gives no step
    clear = 1'b0; start = 1'b1; mode = 1'b0;
    step(4);
    chk("t5_tick",     tick,     1'b1);
    start = 1'b0;
    step(1);
    chk("t5_idle",     running,  1'b0);
    chk("t5_nostep",   count,    4'h1);
    start = 1'b1;
    step(3);
    chk("t5_early",    tick,     1'b0);
    step(1);
    chk("t5_retick",   tick,     1'b1);
    step(1);
    chk("t5_cnt2",     count,    4'h2);

    // 6: asynchronous reset mid-run
    step(2);
    reset = 1'b1;
    #2;
    chk("t6_rst_cnt",  count,    4'h0);
    chk("t6_rst_run",  running,  1'b0);
    chk("t6_rst_tick", tick,     1'b0);
    reset = 1'b0;
    step(4);
    chk("t6_tick",     tick,     1'b1);
    step(1);
    chk("t6_cnt1",     count,    4'h1);
    // clear while counting up
    step(2);
    clear = 1'b1;
    step(1);
    chk("t6_clr_cnt",  count,    4'h0);
    chk("t6_clr_run",  running,  1'b0);
    clear = 1'b0;
    step(3);
    chk("t6_clr_early", tick,    1'b0);
    step(1);
    chk("t6_clr_tick", tick,     1'b1);
    step(1);
    chk("t6_clr_cnt1", count,    4'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/updown_counter_ctrl.md
# updown_counter_ctrl

Parametrised up/down counter controller combining the control FSM, a tick prescaler and the count register in one block. It replaces the separate control FSM and clock divider pair: the counter advances on an internal enable tick instead of a derived clock. It reports protocol violations and overflow through a coded error output, and it recovers through an explicit clear instead of locking up.

## Interface
Parameters:
- WIDTH, 8, count register width in bits (≥2)
- DIVISOR, 50, clk cycles per count step (≥2); use 50000000 for 1 Hz at 50 MHz on hardware
- WRAP, 1, 1: count wraps at the bounds; 0: stepping past a bound is error code 3

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- start  in  1  level; 1 = run requested (S)
- mode  in  1  level; 0 = count up, 1 = count down (M)
- load  in  1  level; load request (L)
- clear  in  1  level; synchronous clear / error acknowledge
- load_value  in  WIDTH  value captured in LOAD
- count  out  WIDTH  current count (registered)
- running  out  1  1 in UP or DOWN
- dir  out  1  1 in DOWN
- loading  out  1  1 in LOAD
- tick  out  1  one-cycle step strobe
- error  out  1  1 in ERR
- err_code  out  2  0 none, 1 mode change while running, 2 load while running, 3 overflow/underflow

## Operation
- States: IDLE, LOAD, UP, DOWN, ERR. Outputs running/dir/loading/error are decoded from the state register only (Moore).
- clear has top priority in every state except ERR. It forces count←0, err_code←0 and next state←IDLE.
- IDLE: load→LOAD; else start→(mode ? DOWN : UP); else stay. count holds.
- LOAD: count←load_value on every clock edge in LOAD. Next state: ~start→IDLE; else mode→DOWN; else UP.
- UP, checked in priority order:
  - ~start→IDLE, count holds
  - mode→ERR, code 1
  - load→ERR, code 2
  - tick with count=2^WIDTH−1: WRAP=1 gives count←0; WRAP=0 gives ERR, code 3, count holds
  - tick otherwise: count←count+1
- DOWN: same as UP with these differences: the error check is ~mode (code 1), the step is count−1, and the bound is 0 (wraps to 2^WIDTH−1 when WRAP=1).
- ERR:
  - Sticky; count and err_code hold.
  - Exits to IDLE only when clear=1 and start=0; err_code←0 on exit.
  - clear=1 with start=1 stays in ERR.
- Unreachable state encodings return to IDLE.
- Prescaler: internal counter 0..DIVISOR−1.
  - Held at 0 outside UP/DOWN.
  - Increments each cycle in UP/DOWN and wraps to 0 after DIVISOR−1.
  - tick=1 when state∈{UP,DOWN} and prescaler=DIVISOR−1.
  - A transition out of UP/DOWN resets the prescaler, so a new run starts from 0.
- Arithmetic is modulo 2^WIDTH. The overflow check is on the pre-step value.

## Timing
- Reset values: state IDLE, count 0, prescaler 0, err_code 0; running, dir, loading, tick and error all 0.
- Inputs are sampled on the rising edge of clk. A state change is visible one cycle after the inputs are applied.
- First step occurs DIVISOR cycles after entering UP/DOWN: tick is high in the DIVISOR-th cycle in that state, and count updates on that edge. Steady rate is one step per DIVISOR cycles.
- A tick coinciding with ~start, a mode error or a load error produces no step; the transition wins.
- Entering ERR with code 3: count keeps the bound value and no wrap occurs.
- Reset mid-run: immediate return to IDLE with count 0, no tick.
- The UP→DOWN direct path does not exist. A direction change requires start=0 (back to IDLE) first.
- Inputs are synchronous. Debouncing and synchronising switches is external.

## Test plan
Test parameters: WIDTH=4, DIVISOR=4, WRAP=1 unless stated.
1. Reset, then start=1, mode=0 -> running=1 next cycle; count=1 after 4 cycles, 2 after 8; tick is a single-cycle pulse every 4 cycles.
2. load=1 with load_value=4'hD in IDLE, then load=0, start=1, mode=1 -> loading=1 for one cycle, count=D, then DOWN; count=C after 4 cycles.
3. Up-count from E -> F then 0 on successive ticks. With WRAP=0: at F, next tick gives error=1, err_code=3, count stays F.
4. Running UP, toggle mode=1 -> ERR, err_code=1. Running DOWN, assert load -> ERR, err_code=2. clear=1 with start=1 -> stays ERR. Then clear=1, start=0 -> IDLE, err_code=0, count unchanged.
5. Tick cycle coinciding with start=0 -> IDLE, count unchanged. Restart -> first step again 4 cycles later.
6. Assert reset mid-run, and separately clear=1 in UP -> IDLE, count=0, prescaler restarts.
